// File: rtl/mfi_pkg.sv
// Shared constants, FSM encoding and iAP2 checksum helper for the MFi
// descriptor RAM reader.
package mfi_pkg;

  localparam int MFI_RAM_DEPTH = 2048;
  localparam int MFI_RAM_AW    = $clog2(MFI_RAM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_CSUM = 2'd2,
    ST_FIN  = 2'd3
  } mfi_state_e;

  // iAP2 checksum byte: two's complement of the 8-bit running sum.
  function automatic logic [7:0] csum8(input logic [7:0] sum);
    return ~sum + 8'd1;
  endfunction

endpackage

// File: rtl/mfi_msg_reader_if.sv
// Byte stream (valid/ready) from the message reader to the iAP2 framer.
interface mfi_msg_reader_if #(
  parameter int DW = 8
);
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (output m_valid, m_data, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/mfi_skid_buf.sv
// Two-entry byte+last buffer; the head register drives the output directly,
// the tail catches a beat that arrives while the head is stalled.
module mfi_skid_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic [1:0]    occ,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  logic [1:0]    occ_r;
  logic [DW-1:0] head_data_r;
  logic [DW-1:0] tail_data_r;
  logic          head_last_r;
  logic          tail_last_r;

  // Buffer storage and occupancy; the writer never pushes into a full, unpopped buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r       <= 2'd0;
      head_data_r <= {DW{1'b0}};
      tail_data_r <= {DW{1'b0}};
      head_last_r <= 1'b0;
      tail_last_r <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_r == 2'd0) begin
            head_data_r <= push_data;
            head_last_r <= push_last;
          end else begin
            tail_data_r <= push_data;
            tail_last_r <= push_last;
          end
          occ_r <= occ_r + 2'd1;
        end
        2'b01: begin
          head_data_r <= tail_data_r;
          head_last_r <= tail_last_r;
          occ_r       <= occ_r - 2'd1;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            head_data_r <= push_data;
            head_last_r <= push_last;
          end else begin
            head_data_r <= tail_data_r;
            head_last_r <= tail_last_r;
            tail_data_r <= push_data;
            tail_last_r <= push_last;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

  assign occ       = occ_r;
  assign out_valid = (occ_r != 2'd0);
  assign out_data  = head_data_r;
  assign out_last  = head_last_r;

endmodule

// File: rtl/mfi_msg_reader.sv
// Reads a message from port A of the MFi descriptor RAM and streams it out
// byte by byte, optionally followed by the iAP2 checksum byte.
module mfi_msg_reader
  import mfi_pkg::*;
#(
  parameter int AW = MFI_RAM_AW,
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [AW-1:0]    cmd_len,
  input  logic             cmd_csum,
  output logic             ram_ce,
  output logic             ram_oce,
  output logic [AW-1:0]    ram_ad,
  input  logic [DW-1:0]    ram_dout,
  mfi_msg_reader_if.master m_if,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

  mfi_state_e    state_r, state_nx_s;
  logic [AW-1:0] addr_r;
  logic [AW-1:0] issue_rem_r;
  logic          csum_en_r;
  logic [DW-1:0] sum_r;
  logic          in_flight_r;
  logic          in_flight_last_r;
  logic          done_r;

  logic          accept_s;
  logic          issue_s;
  logic          pop_s;
  logic          push_s;
  logic [DW-1:0] push_data_s;
  logic          push_last_s;
  logic          done_set_s;
  logic          drained_s;
  logic [1:0]    occ_s;
  logic [2:0]    level_s;
  logic          buf_valid_s;

  assign cmd_ready = !rst && (state_r == ST_IDLE);
  assign accept_s  = cmd_valid && cmd_ready;
  assign pop_s     = buf_valid_s && m_if.m_ready;
  assign drained_s = (occ_s == 2'd0) || ((occ_s == 2'd1) && pop_s);

  // A read may only be issued if its byte is guaranteed a slot when it returns next cycle.
  assign level_s = {1'b0, occ_s} + {2'b00, in_flight_r} - {2'b00, pop_s};
  assign issue_s = !rst && (state_r == ST_READ) && (issue_rem_r != {AW{1'b0}})
                   && (level_s < 3'd2);

  assign ram_ce  = issue_s;
  assign ram_oce = issue_s;
  assign ram_ad  = addr_r;
  assign busy    = (state_r != ST_IDLE);
  assign done    = done_r;
  assign m_if.m_valid = buf_valid_s;

  // Next-state decode plus buffer push selection.
  always_comb begin
    state_nx_s  = state_r;
    push_s      = 1'b0;
    push_data_s = ram_dout;
    push_last_s = 1'b0;
    done_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (cmd_len != {AW{1'b0}}) begin
            state_nx_s = ST_READ;
          end else if (cmd_csum) begin
            state_nx_s = ST_CSUM;
          end else begin
            state_nx_s = ST_FIN;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (in_flight_r) begin
          push_s      = 1'b1;
          push_last_s = in_flight_last_r && !csum_en_r;
          if (in_flight_last_r) begin
            state_nx_s = csum_en_r ? ST_CSUM : ST_FIN;
          end else begin
            state_nx_s = ST_READ;
          end
        end else begin
          state_nx_s = ST_READ;
        end
      end
      ST_CSUM: begin
        push_data_s = csum8(sum_r);
        push_last_s = 1'b1;
        if ((occ_s != 2'd2) || pop_s) begin
          push_s     = 1'b1;
          state_nx_s = ST_FIN;
        end else begin
          state_nx_s = ST_CSUM;
        end
      end
      ST_FIN: begin
        if (drained_s) begin
          done_set_s = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_FIN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register, command latches, read pipeline and running checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      addr_r           <= {AW{1'b0}};
      issue_rem_r      <= {AW{1'b0}};
      csum_en_r        <= 1'b0;
      sum_r            <= {DW{1'b0}};
      in_flight_r      <= 1'b0;
      in_flight_last_r <= 1'b0;
      done_r           <= 1'b0;
    end else begin
      state_r          <= state_nx_s;
      in_flight_r      <= issue_s;
      in_flight_last_r <= issue_s && (issue_rem_r == ONE_A);
      done_r           <= done_set_s;
      if (accept_s) begin
        addr_r      <= cmd_addr;
        issue_rem_r <= cmd_len;
        csum_en_r   <= cmd_csum;
        sum_r       <= {DW{1'b0}};
      end else if (issue_s) begin
        addr_r      <= addr_r + ONE_A;
        issue_rem_r <= issue_rem_r - ONE_A;
      end else begin
        addr_r      <= addr_r;
      end
      if (push_s && (state_r == ST_READ)) begin
        sum_r <= sum_r + ram_dout;
      end else begin
        sum_r <= (accept_s) ? {DW{1'b0}} : sum_r;
      end
    end
  end

  mfi_skid_buf #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .push_last (push_last_s),
    .pop       (pop_s),
    .occ       (occ_s),
    .out_valid (buf_valid_s),
    .out_data  (m_if.m_data),
    .out_last  (m_if.m_last)
  );

endmodule

// File: doc/mfi_msg_reader.md
Name: mfi_msg_reader

Overview:
- Downstream consumer of the 2048x8 MFi/iAP2 descriptor RAM, on its port A.
- Takes a command {start address, length, append-checksum}, issues byte reads to the RAM and absorbs its 1-cycle read latency.
- Streams the bytes out on a valid/ready byte interface with full backpressure, optionally appending the iAP2 two's-complement checksum.
- Feeds the iAP2 link framer / UART transmit path.

Parameters:
- AW, 11, RAM address width (2048 entries).
- DW, 8, data width; fixed at 8 for checksum semantics.

Ports:
- clk  in  1  single system clock; also drives RAM clka.
- rst  in  1  synchronous active-high reset; also drives RAM reseta.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  AW  start address.
- cmd_len  in  AW  byte count, 0..2047.
- cmd_csum  in  1  append checksum byte after payload.
- ram_ce  out  1  RAM port A clock enable (cea).
- ram_oce  out  1  RAM port A output clock enable (ocea); equals ram_ce.
- ram_ad  out  AW  RAM port A address (ada).
- ram_dout  in  DW  RAM port A read data (douta); valid the cycle after ram_ce.
- m_valid  out  1  output byte valid.
- m_ready  in  1  output byte accepted.
- m_data  out  DW  output byte.
- m_last  out  1  marks final byte of the message.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the message completes.

Behaviour:
- Reset values: cmd_ready=0 during rst then 1; ram_ce=0; ram_ad=0; m_valid=0; m_data=0; m_last=0; busy=0; done=0. Buffer emptied, in-flight read discarded, checksum accumulator=0.
- FSM states: IDLE, READ, CSUM, FIN.
- IDLE: cmd_ready=1. On accept, latch addr, len, csum flag and clear sum.
  - len>0 -> READ.
  - len==0 && csum -> CSUM.
  - len==0 && !csum -> FIN.
- READ: issue a read (ram_ce=1, ram_ad=addr) only when occupancy + in_flight - pop < 2.
  - Each issue increments addr modulo 2048 (0x7FF wraps to 0x000) and decrements the remaining issue count.
  - Data returning the next cycle is pushed into a 2-entry skid buffer; sum += byte, 8-bit wrap.
  - When the last byte is pushed: csum ? CSUM : FIN.
- CSUM: pushes (~sum + 1) mod 256 into the buffer once space allows, then -> FIN. Its m_last=1; payload bytes carry m_last=0.
- Without csum, the final payload byte carries m_last=1.
- FIN: waits until the buffer has drained (last beat accepted); done=1 for one cycle; -> IDLE.
- len==0 && !csum: no output beat; done pulses 2 cycles after accept.
- Latency: command accepted at cycle T -> ram_ce at T+1 -> first m_valid at T+3.
- Throughput: sustained 1 byte/cycle while m_ready=1.
- Output hold rule: m_data and m_last are stable while m_valid && !m_ready. No byte is lost or duplicated under any m_ready pattern.
- cmd_valid outside IDLE is ignored; a new command cannot overlap an active one.
- rst asserted mid-message: all outputs return to reset values the next cycle. The partial message is abandoned with no m_last and no done.
- Port B of the RAM is not touched by this block.

Decomposition:
- Shared package mfi_pkg holds:
  - constants MFI_RAM_AW=11, MFI_RAM_DEPTH=2048;
  - the FSM state enum;
  - checksum function csum8(sum) = ~sum+1.
- One sub-module, mfi_skid_buf: 2-entry byte+last buffer with push/pop, occupancy output, registered outputs.

Test Plan:
- Basic: RAM holding its power-up contents; cmd addr=0x000, len=4, csum=1, m_ready=1 -> bytes FF,55,02,00,AA; m_last only on AA; done 1 cycle after AA accepted; first m_valid at T+3.
- Wrap: addr=0x7FE, len=3, csum=1 -> ram_ad sequence 7FE,7FF,000; bytes FF,FF,FF,03.
- Backpressure: same as Basic with m_ready toggling 1,0,0,1,0,1… random -> identical byte sequence; m_data stable while stalled; in-flight reads never exceed buffer space.
- Zero length: len=0, csum=1 -> single beat 00 with m_last=1. len=0, csum=0 -> no beat; done pulses at T+2.
- Reset mid-op: addr=0x000, len=40, rst after 5 beats -> next cycle m_valid=0, ram_ce=0, busy=0. A following cmd addr=0x004 len=2 csum=0 yields EE,10 with m_last on 10.
- Ignored command: cmd_valid held high during an active message -> cmd_ready=0, no second message starts until IDLE.
